// File: rtl/datapath_unit_if.sv
// datapath_unit_if: control-strobe and observation bundle between the control
// unit (master) and the datapath (slave).
//   regSel/aluSel       register index / ALU op select        (master -> slave)
//   Rin/Rout/RAin/RCout  register and bus transfer strobes     (master -> slave)
//   genConst/constIn    drive constIn onto the internal bus    (master -> slave)
//   bus                 current internal bus value             (slave -> master)
//   raOut/rcOut         RA and RC contents                     (slave -> master)
//   carry/zero          registered ALU flags                   (slave -> master)
interface datapath_unit_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       regSel;
    logic [2:0]       aluSel;
    logic             Rin;
    logic             Rout;
    logic             RAin;
    logic             RCout;
    logic             genConst;
    logic [WIDTH-1:0] constIn;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] raOut;
    logic [WIDTH-1:0] rcOut;
    logic             carry;
    logic             zero;

    modport master (
        output regSel, aluSel, Rin, Rout, RAin, RCout, genConst, constIn,
        input  bus, raOut, rcOut, carry, zero
    );

    modport slave (
        input  regSel, aluSel, Rin, Rout, RAin, RCout, genConst, constIn,
        output bus, raOut, rcOut, carry, zero
    );
endinterface

// File: rtl/datapath_unit.sv
// datapath_unit: register bank, ALU operand latch RA, result register RC,
// carry/zero flags and one internal bus, driven by per-cycle control strobes.
//   clk  system clock, all state updates on the rising edge
//   rst  asynchronous active-low reset
//   dp   control strobes in, bus/RA/RC/flags out (see datapath_unit_if)
// The interface WIDTH must match this module's WIDTH.
module datapath_unit #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8   // 1..8, addressed by the 3-bit regSel
) (
    input  logic              clk,
    input  logic              rst,
    datapath_unit_if.slave    dp
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] ra_q, rc_q;
    logic             carry_q, zero_q;

    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] bus_w;
    logic [WIDTH-1:0] rc_d;
    logic             carry_d, zero_d;
    logic [WIDTH:0]   ext;

    // Register read; an index outside the bank reads as 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (dp.regSel == 3'(i)) rd_data = regs_q[i];
        end
    end

    // Bus source priority: genConst > RCout > Rout, idle bus is 0.
    always_comb begin
        bus_w = '0;
        if (dp.genConst)   bus_w = dp.constIn;
        else if (dp.RCout) bus_w = rc_q;
        else if (dp.Rout)  bus_w = rd_data;
    end

    // ALU: A = RA, B = bus. Arithmetic is done one bit wider so the top bit
    // is carry-out for ADD and borrow for SUB.
    always_comb begin
        ext     = '0;
        rc_d    = '0;
        carry_d = 1'b0;
        case (dp.aluSel)
            3'b001: begin
                ext     = {1'b0, ra_q} + {1'b0, bus_w};
                rc_d    = ext[WIDTH-1:0];
                carry_d = ext[WIDTH];
            end
            3'b010: begin
                ext     = {1'b0, ra_q} - {1'b0, bus_w};
                rc_d    = ext[WIDTH-1:0];
                carry_d = ext[WIDTH];
            end
            3'b011: rc_d = ra_q & bus_w;
            3'b100: rc_d = ra_q | bus_w;
            3'b101: rc_d = ra_q ^ bus_w;
            3'b110: rc_d = ~bus_w;
            3'b111: begin
                rc_d    = {bus_w[WIDTH-2:0], 1'b0};
                carry_d = bus_w[WIDTH-1];
            end
            default: ;
        endcase
        zero_d = (rc_d == '0);
    end

    // All sinks sample the pre-edge bus, so RCout+Rin / RCout+RAin see the
    // old RC and the ALU sees the old RA.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            if (dp.Rin) begin
                for (int i = 0; i < NREGS; i++) begin
                    if (dp.regSel == 3'(i)) regs_q[i] <= bus_w;
                end
            end
            if (dp.RAin) ra_q <= bus_w;
            if (dp.aluSel != 3'b000) begin
                rc_q    <= rc_d;
                carry_q <= carry_d;
                zero_q  <= zero_d;
            end
        end
    end

    assign dp.bus   = bus_w;
    assign dp.raOut = ra_q;
    assign dp.rcOut = rc_q;
    assign dp.carry = carry_q;
    assign dp.zero  = zero_q;

endmodule
